iob_sync_handshake_rx: RTL



---
 rtl/iob_cdc_pkg.sv | 12 +
 rtl/iob_sync_srst.sv | 36 +++
 rtl/iob_sync_handshake_rx.sv | 99 +++++++++
 3 files changed

// File: rtl/iob_cdc_pkg.sv
// Definitions shared by the toggle-handshake CDC sender and receiver blocks.
// Holds the handshake FSM encoding and the synchronizer depth.
package iob_cdc_pkg;

   localparam int SYNC_STAGES = 2;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } hs_state_e;

endpackage

// File: rtl/iob_sync_srst.sv
// Multi-flop synchronizer for asynchronous inputs, synchronous active-high reset.
// Depth comes from the shared CDC package so sender and receiver stay matched.
module iob_sync_srst
   import iob_cdc_pkg::*;
#(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] stage_q [SYNC_STAGES];
   logic [WIDTH-1:0] stage_d [SYNC_STAGES];

   assign stage_d[0] = d_i;

   genvar gi;
   generate
      for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_chain
         assign stage_d[gi] = stage_q[gi-1];
      end
   endgenerate

   always_ff @(posedge clk) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
         if (rst) stage_q[i] <= RST_VAL;
         else     stage_q[i] <= stage_d[i];
      end
   end

   assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/iob_sync_handshake_rx.sv
// Receiving side of a toggle-handshake multi-bit CDC: synchronizes the request
// toggle, captures the sender's word, offers it via valid/ready and toggles ack.
module iob_sync_handshake_rx
   import iob_cdc_pkg::*;
#(
   parameter int                DATA_W  = 32,
   parameter logic [DATA_W-1:0] RST_VAL = '0,
   parameter int                CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_tgl_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              ack_tgl_o,
   output logic [DATA_W-1:0] data_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic              err_o,
   output logic [CNT_W-1:0]  xfer_cnt_o
);

   hs_state_e         state_q, state_d;
   logic              req_seen_q, req_seen_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              ack_q, ack_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              req_s;
   logic              new_req;

   iob_sync_srst #(
      .WIDTH   (1),
      .RST_VAL (1'b0)
   ) u_req_sync (
      .clk (clk),
      .rst (rst),
      .d_i (req_tgl_i),
      .q_o (req_s)
   );

   assign new_req = (req_s != req_seen_q);

   always_comb begin
      state_d    = state_q;
      req_seen_d = req_seen_q;
      data_d     = data_q;
      ack_d      = ack_q;
      err_d      = err_q;
      cnt_d      = cnt_q;
      case (state_q)
         IDLE: begin
            // data_i is guaranteed stable here: the sender holds it until ack.
            if (new_req) begin
               data_d     = data_i;
               req_seen_d = req_s;
               state_d    = HOLD;
            end
         end
         HOLD: begin
            // A second toggle before our ack is a sender fault; absorb it once.
            if (new_req) begin
               err_d      = 1'b1;
               req_seen_d = req_s;
            end
            if (ready_i) begin
               ack_d   = ~ack_q;
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         req_seen_q <= 1'b0;
         data_q     <= RST_VAL;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         req_seen_q <= req_seen_d;
         data_q     <= data_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         cnt_q      <= cnt_d;
      end
   end

   assign valid_o    = (state_q == HOLD);
   assign data_o     = data_q;
   assign ack_tgl_o  = ack_q;
   assign err_o      = err_q;
   assign xfer_cnt_o = cnt_q;

endmodule
